// File: rtl/myo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : myo_ctrl_pkg
//  Description : Shared measurement-mode codes, PID control FSM state
//                encoding and output-limit helper for the myo motor loop.
//  Revision    : 1.0  initial release
// ============================================================================
package myo_ctrl_pkg;

  localparam logic [1:0] MODE_POSITION     = 2'd0;
  localparam logic [1:0] MODE_VELOCITY     = 2'd1;
  localparam logic [1:0] MODE_DISPLACEMENT = 2'd2;
  localparam logic [1:0] MODE_RESERVED     = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_WAIT_BUSY = 4'd2,
    ST_WAIT_DONE = 4'd3,
    ST_LATCH     = 4'd4,
    ST_DEADBAND  = 4'd5,
    ST_MULT      = 4'd6,
    ST_ACCUM     = 4'd7,
    ST_OUT       = 4'd8
  } pid_state_e;

  // pwmRef is 16-bit signed, so any requested limit above 32767 is capped there.
  function automatic logic [14:0] out_limit_cap(input logic [15:0] lim);
    return (lim > 16'd32767) ? 15'h7fff : lim[14:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/myo_sat_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : myo_sat_clamp
//  Description : Symmetric signed clamp; limits value_i to +/-limit_i and
//                narrows the result to OUT_W bits. limit_i is unsigned and
//                must be representable as a positive OUT_W-bit number.
//  Revision    : 1.0  initial release
// ============================================================================
module myo_sat_clamp #(
  parameter int IN_W  = 49,
  parameter int LIM_W = 32,
  parameter int OUT_W = 48
) (
  input  logic signed [IN_W-1:0]  value_i,
  input  logic        [LIM_W-1:0] limit_i,
  output logic signed [OUT_W-1:0] value_o
);

  // One guard bit so that the negated limit cannot overflow.
  localparam int EW = IN_W + 1;

  logic signed [EW-1:0] val_ext;
  logic signed [EW-1:0] pos_lim;
  logic signed [EW-1:0] neg_lim;

  // Compare at the extended width, then narrow the selected value.
  always_comb begin
    val_ext = EW'(value_i);
    pos_lim = $signed(EW'(limit_i));
    neg_lim = -pos_lim;
    if (val_ext > pos_lim) begin
      value_o = pos_lim[OUT_W-1:0];
    end else if (val_ext < neg_lim) begin
      value_o = neg_lim[OUT_W-1:0];
    end else begin
      value_o = val_ext[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/myo_pid_controller.sv
`default_nettype none
// ============================================================================
//  Module      : myo_pid_controller
//  Description : Paces SPI frames at a fixed rate, latches the returned
//                measurement and runs a multi-cycle saturating PID step that
//                produces the signed pwmRef command for the next frame.
//  Revision    : 1.0  initial release
// ============================================================================
module myo_pid_controller
  import myo_ctrl_pkg::*;
#(
  parameter int UPDATE_DIV = 50000,
  parameter int OUT_SHIFT  = 8,
  parameter int TIMEOUT    = 4096,
  parameter int ACC_W      = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic        [1:0]  mode,
  input  logic signed [31:0] setpoint,
  input  logic        [15:0] Kp,
  input  logic        [15:0] Ki,
  input  logic        [15:0] Kd,
  input  logic        [15:0] deadband,
  input  logic        [31:0] integral_limit,
  input  logic        [15:0] output_limit,
  input  logic               spi_done,
  input  logic signed [31:0] position,
  input  logic signed [15:0] velocity,
  input  logic signed [15:0] displacement,
  output logic               start,
  output logic signed [15:0] pwmRef,
  output logic               frame_timeout
);

  localparam int CNT_W  = $clog2(UPDATE_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  // 34-bit error difference times 17-bit signed gain.
  localparam int PROD_W = 51;
  localparam int SUM_W  = ACC_W + 2;
  localparam logic [ACC_W-2:0] PROD_LIM = '1;

  pid_state_e               state_q;
  logic [CNT_W-1:0]         tick_cnt_q;
  logic [TO_W-1:0]          wait_cnt_q;
  logic                     start_q;
  logic                     timeout_q;
  logic signed [15:0]       pwm_q;
  logic [1:0]               mode_q;
  logic                     zero_out_q;
  logic signed [32:0]       err_q;
  logic signed [32:0]       last_err_q;
  logic signed [ACC_W-1:0]  integral_q;
  logic signed [ACC_W-1:0]  p_q;
  logic signed [ACC_W-1:0]  d_q;
  logic signed [ACC_W-1:0]  iinc_q;

  logic                     tick_d;
  logic signed [31:0]       meas_d;
  logic signed [32:0]       err_d;
  logic signed [32:0]       abs_err_d;
  logic signed [33:0]       derr_d;
  logic signed [PROD_W-1:0] p_full_d;
  logic signed [PROD_W-1:0] d_full_d;
  logic signed [PROD_W-1:0] i_full_d;
  logic signed [ACC_W-1:0]  p_sat_d;
  logic signed [ACC_W-1:0]  d_sat_d;
  logic signed [ACC_W-1:0]  i_sat_d;
  logic signed [ACC_W:0]    integ_sum_d;
  logic signed [ACC_W-1:0]  integ_d;
  logic signed [SUM_W-1:0]  pid_sum_d;
  logic signed [SUM_W-1:0]  pid_shift_d;
  logic signed [15:0]       pwm_d;

  assign start         = start_q;
  assign pwmRef        = pwm_q;
  assign frame_timeout = timeout_q;
  assign tick_d        = (tick_cnt_q == CNT_W'(UPDATE_DIV - 1));

  // Free-running update pacer; tick_d marks the wrap cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick_d) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  // Measurement select, error, and all full-precision PID arithmetic.
  always_comb begin
    case (mode)
      MODE_POSITION:     meas_d = position;
      MODE_VELOCITY:     meas_d = 32'(velocity);
      MODE_DISPLACEMENT: meas_d = 32'(displacement);
      default:           meas_d = '0;
    endcase
    err_d       = 33'(setpoint) - 33'(meas_d);
    abs_err_d   = err_q[32] ? -err_q : err_q;
    derr_d      = 34'(err_q) - 34'(last_err_q);
    p_full_d    = PROD_W'(err_q)  * PROD_W'($signed({1'b0, Kp}));
    d_full_d    = PROD_W'(derr_d) * PROD_W'($signed({1'b0, Kd}));
    i_full_d    = PROD_W'(err_q)  * PROD_W'($signed({1'b0, Ki}));
    integ_sum_d = (ACC_W+1)'(integral_q) + (ACC_W+1)'(iinc_q);
    pid_sum_d   = SUM_W'(p_q) + SUM_W'(integral_q) + SUM_W'(d_q);
    pid_shift_d = pid_sum_d >>> OUT_SHIFT;
  end

  myo_sat_clamp #(.IN_W(PROD_W), .LIM_W(ACC_W-1), .OUT_W(ACC_W)) u_sat_p (
    .value_i(p_full_d), .limit_i(PROD_LIM), .value_o(p_sat_d)
  );

  myo_sat_clamp #(.IN_W(PROD_W), .LIM_W(ACC_W-1), .OUT_W(ACC_W)) u_sat_d (
    .value_i(d_full_d), .limit_i(PROD_LIM), .value_o(d_sat_d)
  );

  myo_sat_clamp #(.IN_W(PROD_W), .LIM_W(ACC_W-1), .OUT_W(ACC_W)) u_sat_i (
    .value_i(i_full_d), .limit_i(PROD_LIM), .value_o(i_sat_d)
  );

  myo_sat_clamp #(.IN_W(ACC_W+1), .LIM_W(32), .OUT_W(ACC_W)) u_clamp_integral (
    .value_i(integ_sum_d), .limit_i(integral_limit), .value_o(integ_d)
  );

  myo_sat_clamp #(.IN_W(SUM_W), .LIM_W(15), .OUT_W(16)) u_clamp_output (
    .value_i(pid_shift_d), .limit_i(out_limit_cap(output_limit)), .value_o(pwm_d)
  );

  // Frame handshake and PID sequencing; pwmRef is only written in ST_OUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
      pwm_q      <= '0;
      mode_q     <= MODE_POSITION;
      zero_out_q <= 1'b0;
      err_q      <= '0;
      last_err_q <= '0;
      integral_q <= '0;
      p_q        <= '0;
      d_q        <= '0;
      iinc_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A tick with the frame controller busy is simply dropped.
          if (tick_d && spi_done) begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!spi_done) begin
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_DONE;
          end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (spi_done) begin
            state_q <= ST_LATCH;
          end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        ST_LATCH: begin
          err_q      <= err_d;
          mode_q     <= mode;
          zero_out_q <= !enable || (mode == MODE_RESERVED);
          // Loop disabled, reserved mode or a new measurement: restart history.
          if (!enable || (mode == MODE_RESERVED) || (mode != mode_q)) begin
            integral_q <= '0;
            last_err_q <= '0;
          end
          state_q <= ST_DEADBAND;
        end
        ST_DEADBAND: begin
          if (abs_err_d <= $signed({17'd0, deadband})) begin
            err_q <= '0;
          end
          state_q <= ST_MULT;
        end
        ST_MULT: begin
          p_q     <= p_sat_d;
          d_q     <= d_sat_d;
          iinc_q  <= i_sat_d;
          state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (zero_out_q) begin
            integral_q <= '0;
            last_err_q <= '0;
          end else begin
            integral_q <= integ_d;
            last_err_q <= err_q;
          end
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          pwm_q   <= zero_out_q ? 16'sd0 : pwm_d;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
